// File: rtl/skew_feed_ctrl.sv
// Tile sequencer for the per-lane skew chains in front of the systolic array.
// It accepts len_i vectors, drains rows_p-1 zero beats, then pulses done_o.
module skew_feed_ctrl #(
  parameter int rows_p  = 4,
  parameter int width_p = 8,
  parameter int len_w_p = 8
) (
  input  logic                        clk_i,
  input  logic                        reset_ni,
  input  logic                        start_i,
  input  logic [len_w_p-1:0]          len_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic [rows_p*width_p-1:0]   data_i,
  output logic                        shift_en_o,
  output logic [rows_p*width_p-1:0]   shift_data_o,
  output logic [rows_p-1:0]           lane_valid_o,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int DW = $clog2(rows_p + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FEED  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [len_w_p-1:0] BEAT_ONE   = len_w_p'(1);
  localparam logic [DW-1:0]      DRAIN_ONE  = DW'(1);
  localparam logic [DW-1:0]      DRAIN_LOAD = DW'(rows_p - 1);

  logic [1:0]          r_state;
  logic [len_w_p-1:0]  r_beat;
  logic [DW-1:0]       r_drain;
  logic [rows_p-1:0]   r_vh;

  logic                w_feed;
  logic                w_drain;
  logic                w_accept;
  logic                w_shift_en;
  logic [rows_p-1:0]   w_vh_next;

  assign w_feed     = (r_state == S_FEED);
  assign w_drain    = (r_state == S_DRAIN);
  assign w_accept   = w_feed & valid_i;
  assign w_shift_en = w_accept | w_drain;

  assign ready_o      = w_feed;
  assign shift_en_o   = w_shift_en;
  assign shift_data_o = w_feed ? data_i : {(rows_p*width_p){1'b0}};
  assign lane_valid_o = r_vh;
  assign busy_o       = (r_state != S_IDLE);
  assign done_o       = (r_state == S_DONE);

  // Valid history mirrors the chains: lane 0 takes the new beat, lane i the previous lane.
  always_comb begin
    w_vh_next    = r_vh;
    w_vh_next[0] = w_feed;
    for (int i = 1; i < rows_p; i++) begin
      w_vh_next[i] = r_vh[i-1];
    end
  end

  // Tile sequencing: beat counter during FEED, drain counter during DRAIN.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= S_IDLE;
      r_beat  <= {len_w_p{1'b0}};
      r_drain <= {DW{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            if (len_i != {len_w_p{1'b0}}) begin
              r_beat  <= len_i;
              r_state <= S_FEED;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_FEED: begin
          if (valid_i) begin
            r_beat <= r_beat - BEAT_ONE;
            if (r_beat == BEAT_ONE) begin
              if (rows_p == 1) begin
                r_state <= S_DONE;
              end else begin
                r_drain <= DRAIN_LOAD;
                r_state <= S_DRAIN;
              end
            end
          end
        end
        S_DRAIN: begin
          r_drain <= r_drain - DRAIN_ONE;
          if (r_drain == DRAIN_ONE) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // History clears once the tile is done so lane_valid_o idles at zero.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_vh <= {rows_p{1'b0}};
    end else if (r_state == S_DONE) begin
      r_vh <= {rows_p{1'b0}};
    end else if (w_shift_en) begin
      r_vh <= w_vh_next;
    end else begin
      r_vh <= r_vh;
    end
  end

endmodule

// File: tb/tb_skew_feed_ctrl.sv
// Directed bench for skew_feed_ctrl: table-driven tile vectors on a rows_p=4 instance,
// plus hand sequences for async reset mid-drain and a rows_p=1 instance.
module tb_skew_feed_ctrl;

  logic        clk;
  logic        reset_ni;

  logic        start4, valid4, ready4, sh4, busy4, done4;
  logic [7:0]  len4;
  logic [31:0] data4, sd4;
  logic [3:0]  lv4;

  logic        start1, valid1, ready1, sh1, busy1, done1, lv1;
  logic [7:0]  len1;
  logic [7:0]  data1, sd1;

  int n_checks = 0;
  int n_errors = 0;

  skew_feed_ctrl #(.rows_p(4), .width_p(8), .len_w_p(8)) u_dut4 (
    .clk_i(clk), .reset_ni(reset_ni), .start_i(start4), .len_i(len4),
    .valid_i(valid4), .ready_o(ready4), .data_i(data4), .shift_en_o(sh4),
    .shift_data_o(sd4), .lane_valid_o(lv4), .busy_o(busy4), .done_o(done4)
  );

  skew_feed_ctrl #(.rows_p(1), .width_p(8), .len_w_p(8)) u_dut1 (
    .clk_i(clk), .reset_ni(reset_ni), .start_i(start1), .len_i(len1),
    .valid_i(valid1), .ready_o(ready1), .data_i(data1), .shift_en_o(sh1),
    .shift_data_o(sd1), .lane_valid_o(lv1), .busy_o(busy1), .done_o(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        start;
    logic [7:0]  len;
    logic        valid;
    logic [31:0] data;
    logic        e_ready;
    logic        e_sh;
    logic [3:0]  e_lv;
    logic        e_busy;
    logic        e_done;
    logic [31:0] e_sd;
  } vec_t;

  vec_t vq[$];

  localparam logic [31:0] A = 32'h11223344;
  localparam logic [31:0] B = 32'h55667788;
  localparam logic [31:0] C = 32'h99aabbcc;
  localparam logic [31:0] D = 32'hdeadbeef;

  task automatic v(input string nm, input logic st, input logic [7:0] ln, input logic vl,
                   input logic [31:0] dt, input logic er, input logic es, input logic [3:0] el,
                   input logic eb, input logic ed, input logic [31:0] esd);
    vq.push_back('{nm, st, ln, vl, dt, er, es, el, eb, ed, esd});
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  function automatic logic [63:0] pack4();
    return {24'd0, ready4, sh4, lv4, busy4, done4, sd4};
  endfunction

  function automatic logic [63:0] pack1();
    return {51'd0, ready1, sh1, lv1, busy1, done1, sd1};
  endfunction

  function automatic logic [63:0] exp4(input logic r, input logic s, input logic [3:0] l,
                                       input logic b, input logic d, input logic [31:0] sd);
    return {24'd0, r, s, l, b, d, sd};
  endfunction

  function automatic logic [63:0] exp1(input logic r, input logic s, input logic l,
                                       input logic b, input logic d, input logic [7:0] sd);
    return {51'd0, r, s, l, b, d, sd};
  endfunction

  initial begin
    int cyc;
    int shifts;

    // basic tile, len 3, no stalls
    v("t1c0", 1'b1, 8'd3, 1'b1, D, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 32'd0);
    v("t1c1", 1'b0, 8'd0, 1'b1, A, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, A);
    v("t1c2", 1'b0, 8'd0, 1'b1, B, 1'b1, 1'b1, 4'b0001, 1'b1, 1'b0, B);
    v("t1c3", 1'b0, 8'd0, 1'b1, C, 1'b1, 1'b1, 4'b0011, 1'b1, 1'b0, C);
    v("t1c4", 1'b0, 8'd0, 1'b1, D, 1'b0, 1'b1, 4'b0111, 1'b1, 1'b0, 32'd0);
    v("t1c5", 1'b0, 8'd0, 1'b1, D, 1'b0, 1'b1, 4'b1110, 1'b1, 1'b0, 32'd0);
    v("t1c6", 1'b0, 8'd0, 1'b1, D, 1'b0, 1'b1, 4'b1100, 1'b1, 1'b0, 32'd0);
    v("t1c7", 1'b0, 8'd0, 1'b1, D, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b1, 32'd0);
    v("t1c8", 1'b0, 8'd0, 1'b1, D, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 32'd0);
    // stall on cycle 2
    v("t2c0", 1'b1, 8'd3, 1'b0, 32'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 32'd0);
    v("t2c1", 1'b0, 8'd0, 1'b1, A, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, A);
    v("t2c2", 1'b0, 8'd0, 1'b0, B, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b0, B);
    v("t2c3", 1'b0, 8'd0, 1'b1, B, 1'b1, 1'b1, 4'b0001, 1'b1, 1'b0, B);
    v("t2c4", 1'b0, 8'd0, 1'b1, C, 1'b1, 1'b1, 4'b0011, 1'b1, 1'b0, C);
    v("t2c5", 1'b0, 8'd0, 1'b0, 32'd0, 1'b0, 1'b1, 4'b0111, 1'b1, 1'b0, 32'd0);
    v("t2c6", 1'b0, 8'd0, 1'b0, 32'd0, 1'b0, 1'b1, 4'b1110, 1'b1, 1'b0, 32'd0);
    v("t2c7", 1'b0, 8'd0, 1'b0, 32'd0, 1'b0, 1'b1, 4'b1100, 1'b1, 1'b0, 32'd0);
    v("t2c8", 1'b0, 8'd0, 1'b0, 32'd0, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b1, 32'd0);
    v("t2c9", 1'b0, 8'd0, 1'b0, 32'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 32'd0);
    // zero-length tile
    v("t3c0", 1'b1, 8'd0, 1'b1, A, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 32'd0);
    v("t3c1", 1'b0, 8'd0, 1'b1, A, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 32'd0);
    v("t3c2", 1'b0, 8'd0, 1'b1, A, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 32'd0);
    // len 2 lane-valid walk
    v("t4c0", 1'b1, 8'd2, 1'b1, A, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 32'd0);
    v("t4c1", 1'b0, 8'd0, 1'b1, A, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, A);
    v("t4c2", 1'b0, 8'd0, 1'b1, B, 1'b1, 1'b1, 4'b0001, 1'b1, 1'b0, B);
    v("t4c3", 1'b0, 8'd0, 1'b1, C, 1'b0, 1'b1, 4'b0011, 1'b1, 1'b0, 32'd0);
    v("t4c4", 1'b0, 8'd0, 1'b1, C, 1'b0, 1'b1, 4'b0110, 1'b1, 1'b0, 32'd0);
    v("t4c5", 1'b0, 8'd0, 1'b1, C, 1'b0, 1'b1, 4'b1100, 1'b1, 1'b0, 32'd0);
    v("t4c6", 1'b0, 8'd0, 1'b1, C, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b1, 32'd0);
    v("t4c7", 1'b0, 8'd0, 1'b1, C, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 32'd0);
    // same tile with start held during the tile: must be ignored
    v("t6c0", 1'b1, 8'd2, 1'b1, A, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 32'd0);
    v("t6c1", 1'b1, 8'd7, 1'b1, A, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, A);
    v("t6c2", 1'b1, 8'd7, 1'b1, B, 1'b1, 1'b1, 4'b0001, 1'b1, 1'b0, B);
    v("t6c3", 1'b1, 8'd7, 1'b1, C, 1'b0, 1'b1, 4'b0011, 1'b1, 1'b0, 32'd0);
    v("t6c4", 1'b1, 8'd7, 1'b1, C, 1'b0, 1'b1, 4'b0110, 1'b1, 1'b0, 32'd0);
    v("t6c5", 1'b1, 8'd7, 1'b1, C, 1'b0, 1'b1, 4'b1100, 1'b1, 1'b0, 32'd0);
    v("t6c6", 1'b1, 8'd7, 1'b1, C, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b1, 32'd0);
    v("t6c7", 1'b0, 8'd0, 1'b1, C, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 32'd0);

    reset_ni = 1'b0;
    start4 = 1'b0; len4 = 8'd0; valid4 = 1'b0; data4 = 32'd0;
    start1 = 1'b0; len1 = 8'd0; valid1 = 1'b0; data1 = 8'd0;
    data4 = D;
    #12;
    chk("reset_hold4", pack4(), exp4(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 32'd0));
    chk("reset_hold1", pack1(), exp1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    @(posedge clk); #1;
    reset_ni = 1'b1;
    @(negedge clk);
    chk("after_release", pack4(), exp4(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 32'd0));
    @(posedge clk); #1;

    foreach (vq[i]) begin
      start4 = vq[i].start; len4 = vq[i].len; valid4 = vq[i].valid; data4 = vq[i].data;
      @(negedge clk);
      chk(vq[i].name, pack4(),
          exp4(vq[i].e_ready, vq[i].e_sh, vq[i].e_lv, vq[i].e_busy, vq[i].e_done, vq[i].e_sd));
      @(posedge clk); #1;
    end

    // async reset in the middle of DRAIN
    start4 = 1'b1; len4 = 8'd3; valid4 = 1'b1; data4 = A;
    @(posedge clk); #1;
    start4 = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("pre_reset_drain", pack4(), exp4(1'b0, 1'b1, 4'b0111, 1'b1, 1'b0, 32'd0));
    #2;
    reset_ni = 1'b0;
    #1;
    chk("async_reset_now", pack4(), exp4(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 32'd0));
    @(posedge clk); #1;
    chk("async_reset_held", pack4(), exp4(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 32'd0));
    reset_ni = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", pack4(), exp4(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 32'd0));
    @(posedge clk); #1;

    // clean len-1 tile after reset: done expected 5 cycles after start, 4 shifts
    start4 = 1'b1; len4 = 8'd1; valid4 = 1'b1; data4 = B;
    cyc = 0;
    shifts = 0;
    while (cyc < 20) begin
      @(negedge clk);
      if (sh4) shifts++;
      if (done4) break;
      @(posedge clk); #1;
      start4 = 1'b0;
      cyc++;
    end
    chk("clean_tile_done_cycle", 64'(cyc), 64'd5);
    chk("clean_tile_shifts", 64'(shifts), 64'd4);
    @(posedge clk); #1;
    valid4 = 1'b0;

    // rows_p=1: FEED goes straight to DONE, with one stall cycle
    start1 = 1'b1; len1 = 8'd1; valid1 = 1'b0; data1 = 8'h5a;
    @(negedge clk);
    chk("r1_c0", pack1(), exp1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    @(posedge clk); #1;
    start1 = 1'b0;
    @(negedge clk);
    chk("r1_stall", pack1(), exp1(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5a));
    @(posedge clk); #1;
    valid1 = 1'b1; data1 = 8'hc3;
    @(negedge clk);
    chk("r1_feed", pack1(), exp1(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hc3));
    @(posedge clk); #1;
    @(negedge clk);
    chk("r1_done", pack1(), exp1(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("r1_idle", pack1(), exp1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
